// File: rtl/rand_sample_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rand_sample_tx_pkg
// Description : Shared constants, state encodings and helpers for the
//               Gaussian sample transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package rand_sample_tx_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int          CNT_W               = 16;
    localparam logic [15:0] DEFAULT_TRAILER_TAG = 16'hFEED;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STREAM  = 2'd1;
    localparam logic [1:0] TRAILER = 2'd2;

    // Ceiling log2, never less than 1 so a pointer always has an index bit.
    function automatic int log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rand_sample_tx_quad_fifo.sv
`default_nettype none
// ============================================================================
// Module      : quad_fifo
// Description : Synchronous FIFO of sample quads with flush and a look-ahead
//               read port exposing the entry behind the head.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_fifo
    import rand_sample_tx_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head_data,
    output logic [WIDTH-1:0] next_data,
    output logic             full,
    output logic             empty,
    output logic             multi
);

    localparam int AW = log2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic [AW-1:0]    next_idx;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign multi     = (count > (AW+1)'(1));
    assign next_idx  = rd_ptr_q[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign next_data = mem_q[next_idx];

    // A pop frees the slot before the push lands, so push-on-full with pop succeeds.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rand_sample_tx.sv
`default_nettype none
// ============================================================================
// Module      : rand_sample_tx
// Description : Buffers transformed sample quads and streams K samples to the
//               host as 32-bit words, followed by a dropped-quad trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_sample_tx
    import rand_sample_tx_pkg::*;
#(
    parameter int          DELAY       = 1,
    parameter int          XB_SIZE     = 32,
    parameter int          FP_SIZE     = 32,
    parameter int          DEPTH       = 16,
    parameter logic [15:0] TRAILER_TAG = DEFAULT_TRAILER_TAG
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               in_valid,
    input  logic [FP_SIZE-1:0] in_p,
    input  logic [FP_SIZE-1:0] in_q,
    input  logic [FP_SIZE-1:0] in_r,
    input  logic [FP_SIZE-1:0] in_s,
    input  logic               req_valid,
    input  logic [CNT_W-1:0]   req_count,
    output logic               req_ack,
    output logic               fpga_msg_valid,
    output logic [XB_SIZE-1:0] fpga_msg,
    input  logic               fpga_msg_ack,
    output logic               busy,
    output logic               drop_pulse
);

    localparam int QW = 4 * FP_SIZE;

    // DELAY is kept for interface compatibility; registers update with no modelled delay.
    if (DELAY < 0 || XB_SIZE != FP_SIZE || DEPTH < 2) begin : g_param_guard
    end

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]         lane_q, lane_d;
    logic               req_ack_q, req_ack_d;
    logic               msg_valid_q, msg_valid_d;
    logic [XB_SIZE-1:0] msg_q, msg_d;

    logic               fire;
    logic               use_next;
    logic [1:0]         src_lane;
    logic [QW-1:0]      src_quad;
    logic [FP_SIZE-1:0] src_word;
    logic               drop;
    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty, fifo_multi;
    logic [QW-1:0]      fifo_head, fifo_next;

    function automatic logic [FP_SIZE-1:0] lane_word(input logic [QW-1:0] quad,
                                                     input logic [1:0]    lane);
        return quad[(3 - int'(lane)) * FP_SIZE +: FP_SIZE];
    endfunction

    function automatic logic [XB_SIZE-1:0] trailer_word(input logic [CNT_W-1:0] drops);
        return XB_SIZE'({TRAILER_TAG, drops});
    endfunction

    quad_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   ({in_p, in_q, in_r, in_s}),
        .head_data (fifo_head),
        .next_data (fifo_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .multi     (fifo_multi)
    );

    // The word presented after an ack is the next lane, or lane p of the following quad.
    assign fire     = msg_valid_q && fpga_msg_ack;
    assign use_next = fire && (lane_q == 2'd3);
    assign src_lane = fire ? lane_q + 2'd1 : lane_q;
    assign src_quad = use_next ? fifo_next : fifo_head;
    assign src_word = lane_word(src_quad, src_lane);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drop_cnt_d  = drop_cnt_q;
        lane_d      = lane_q;
        req_ack_d   = FALSE;
        msg_valid_d = msg_valid_q;
        msg_d       = msg_q;
        fifo_push   = FALSE;
        fifo_pop    = FALSE;
        fifo_flush  = FALSE;
        drop        = FALSE;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    remaining_d = req_count;
                    req_ack_d   = TRUE;
                    if (req_count != '0) begin
                        state_d = STREAM;
                    end else begin
                        state_d     = TRAILER;
                        msg_valid_d = TRUE;
                        msg_d       = trailer_word(drop_cnt_q);
                    end
                end
            end
            STREAM: begin
                fifo_pop = use_next;
                if (in_valid) begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = TRUE;
                    end else begin
                        drop = TRUE;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
                if (fire) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d     = TRAILER;
                        msg_valid_d = TRUE;
                        msg_d       = trailer_word(drop_cnt_d);
                    end else begin
                        lane_d = src_lane;
                        if (use_next && !fifo_multi) begin
                            msg_valid_d = FALSE;
                        end else begin
                            msg_d = XB_SIZE'(src_word);
                        end
                    end
                end else if (!msg_valid_q && !fifo_empty) begin
                    msg_valid_d = TRUE;
                    msg_d       = XB_SIZE'(src_word);
                end
            end
            TRAILER: begin
                if (fire) begin
                    state_d     = IDLE;
                    msg_valid_d = FALSE;
                    drop_cnt_d  = '0;
                    lane_d      = 2'd0;
                    fifo_flush  = TRUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            drop_cnt_q  <= '0;
            lane_q      <= 2'd0;
            req_ack_q   <= FALSE;
            msg_valid_q <= FALSE;
            msg_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drop_cnt_q  <= drop_cnt_d;
            lane_q      <= lane_d;
            req_ack_q   <= req_ack_d;
            msg_valid_q <= msg_valid_d;
            msg_q       <= msg_d;
        end
    end

    assign req_ack        = req_ack_q;
    assign fpga_msg_valid = msg_valid_q;
    assign fpga_msg       = msg_q;
    assign busy           = (state_q != IDLE);
    assign drop_pulse     = drop && !RESET;

endmodule
`default_nettype wire

// File: tb/tb_rand_sample_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_sample_tx
// Description : Self-checking bench for rand_sample_tx against a queue-based
//               behavioural model of the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_sample_tx;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [31:0] in_p, in_q, in_r, in_s;
    logic        req_valid;
    logic [15:0] req_count;
    logic        req_ack;
    logic        fpga_msg_valid;
    logic [31:0] fpga_msg;
    logic        fpga_msg_ack;
    logic        busy;
    logic        drop_pulse;

    always #5 CLK = ~CLK;

    rand_sample_tx #(
        .DELAY       (1),
        .XB_SIZE     (32),
        .FP_SIZE     (32),
        .DEPTH       (DEPTH),
        .TRAILER_TAG (16'hFEED)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .in_valid       (in_valid),
        .in_p           (in_p),
        .in_q           (in_q),
        .in_r           (in_r),
        .in_s           (in_s),
        .req_valid      (req_valid),
        .req_count      (req_count),
        .req_ack        (req_ack),
        .fpga_msg_valid (fpga_msg_valid),
        .fpga_msg       (fpga_msg),
        .fpga_msg_ack   (fpga_msg_ack),
        .busy           (busy),
        .drop_pulse     (drop_pulse)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 streaming, 2 trailer.
    logic [127:0] m_fifo[$];
    int           m_mode  = 0;
    int           m_lane  = 0;
    int           m_rem   = 0;
    logic [15:0]  m_drops = '0;
    bit           m_valid = 0;
    bit           m_ack   = 0;
    logic [31:0]  m_word  = '0;
    bit           model_live = 0;

    logic [31:0]  log_w[$];
    int           log_c[$];
    int           cyc       = 0;
    int           drop_seen = 0;
    int           ack_seen  = 0;

    function automatic logic [31:0] lanew(input logic [127:0] quad, input int l);
        return quad[127 - 32*l -: 32];
    endfunction

    task automatic model_step();
        bit fire, pop, dropped;
        if (RESET) begin
            m_fifo.delete();
            m_mode = 0; m_lane = 0; m_rem = 0; m_drops = '0;
            m_valid = 0; m_ack = 0; m_word = '0;
            model_live = 1;
            return;
        end
        m_ack = 0;
        fire  = m_valid && fpga_msg_ack;
        case (m_mode)
            0: if (req_valid) begin
                m_ack = 1;
                m_rem = int'(req_count);
                if (req_count != 16'd0) m_mode = 1;
                else begin
                    m_mode = 2; m_valid = 1; m_word = {16'hFEED, m_drops};
                end
            end
            1: begin
                pop = fire && (m_lane == 3);
                if (pop) void'(m_fifo.pop_front());
                dropped = in_valid && (m_fifo.size() >= DEPTH);
                if (dropped && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                if (fire) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = 2; m_valid = 1; m_word = {16'hFEED, m_drops};
                    end else if (!pop) begin
                        m_lane++;
                        m_word = lanew(m_fifo[0], m_lane);
                    end else begin
                        m_lane = 0;
                        if (m_fifo.size() > 0) m_word = lanew(m_fifo[0], 0);
                        else m_valid = 0;
                    end
                end else if (!m_valid && m_fifo.size() > 0) begin
                    m_valid = 1;
                    m_word  = lanew(m_fifo[0], m_lane);
                end
                if (in_valid && !dropped) m_fifo.push_back({in_p, in_q, in_r, in_s});
            end
            default: if (fire) begin
                m_mode = 0; m_valid = 0; m_drops = '0; m_lane = 0;
                m_fifo.delete();
            end
        endcase
    endtask

    // Compare, log handshakes, then advance the model with the inputs the DUT is about to sample.
    initial begin
        bit          exp_drop;
        bit          prev_hold = 0;
        logic [31:0] prev_msg  = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            exp_drop = !RESET && (m_mode == 1) && in_valid && (m_fifo.size() >= DEPTH) &&
                       !(m_valid && fpga_msg_ack && m_lane == 3);
            if (model_live) begin
                check("req_ack", 32'(req_ack), 32'(m_ack));
                check("msg_valid", 32'(fpga_msg_valid), 32'(m_valid));
                if (m_valid) check("msg", fpga_msg, m_word);
                check("busy", 32'(busy), 32'(m_mode != 0));
                check("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
                if (prev_hold && fpga_msg_valid) check("stall_stable", fpga_msg, prev_msg);
            end
            if (fpga_msg_valid && fpga_msg_ack) begin
                log_w.push_back(fpga_msg);
                log_c.push_back(cyc);
            end
            if (drop_pulse) drop_seen++;
            if (req_ack)    ack_seen++;
            prev_hold = fpga_msg_valid && !fpga_msg_ack && !RESET;
            prev_msg  = fpga_msg;
            model_step();
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input int k);
        req_valid = 1'b1;
        req_count = 16'(k);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic push_quad(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        in_valid = 1'b1;
        in_p = a; in_q = b; in_r = c; in_s = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || fpga_msg_valid) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic run_basic(input string tag);
        log_w.delete(); log_c.delete();
        ack_seen     = 0;
        fpga_msg_ack = 1'b1;
        request(8);
        push_quad(32'd1, 32'd2, 32'd3, 32'd4);
        push_quad(32'd5, 32'd6, 32'd7, 32'd8);
        wait_idle(40, {tag, "_timeout"});
        check({tag, "_count"}, 32'(log_w.size()), 32'd9);
        if (log_w.size() == 9) begin
            for (int i = 0; i < 8; i++) check({tag, "_word"}, log_w[i], 32'(i + 1));
            check({tag, "_trailer"}, log_w[8], 32'hFEED0000);
            check({tag, "_back_to_back"}, 32'(log_c[8] - log_c[0]), 32'd8);
        end
        check({tag, "_req_ack_pulses"}, 32'(ack_seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; in_valid = 1'b0; in_p = '0; in_q = '0; in_r = '0; in_s = '0;
        req_valid = 1'b0; req_count = '0; fpga_msg_ack = 1'b0;
        tick(); tick(); tick();
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_valid", 32'(fpga_msg_valid), 32'd0);
        check("rst_msg", fpga_msg, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        RESET = 1'b0;
        tick();

        run_basic("t1");

        // Count not a multiple of 4: lanes 7 and 8 must be flushed, not resent.
        log_w.delete();
        request(6);
        push_quad(32'd1, 32'd2, 32'd3, 32'd4);
        push_quad(32'd5, 32'd6, 32'd7, 32'd8);
        wait_idle(40, "t2_timeout");
        check("t2_count", 32'(log_w.size()), 32'd7);
        if (log_w.size() == 7) begin
            check("t2_w5", log_w[5], 32'd6);
            check("t2_trailer", log_w[6], 32'hFEED0000);
        end
        log_w.delete();
        request(4);
        push_quad(32'd9, 32'd10, 32'd11, 32'd12);
        wait_idle(40, "t2b_timeout");
        check("t2b_count", 32'(log_w.size()), 32'd5);
        if (log_w.size() == 5) begin
            check("t2b_first", log_w[0], 32'd9);
            check("t2b_last", log_w[3], 32'd12);
        end

        // Overflow with the host stalled.
        log_w.delete();
        fpga_msg_ack = 1'b0;
        drop_seen    = 0;
        request(64);
        for (int i = 0; i < 20; i++)
            push_quad(32'(100 + 4*i), 32'(101 + 4*i), 32'(102 + 4*i), 32'(103 + 4*i));
        tick(); tick();
        check("t3_drops", 32'(drop_seen), 32'd4);
        fpga_msg_ack = 1'b1;
        wait_idle(200, "t3_timeout");
        check("t3_count", 32'(log_w.size()), 32'd65);
        if (log_w.size() == 65) begin
            check("t3_first", log_w[0], 32'd100);
            check("t3_last_sample", log_w[63], 32'd163);
            check("t3_trailer", log_w[64], 32'hFEED0004);
        end

        // Zero-length request: trailer only, drop count cleared by the previous trailer.
        log_w.delete();
        ack_seen = 0;
        request(0);
        wait_idle(20, "t5_timeout");
        check("t5_count", 32'(log_w.size()), 32'd1);
        if (log_w.size() == 1) check("t5_trailer", log_w[0], 32'hFEED0000);
        check("t5_req_ack", 32'(ack_seen), 32'd1);

        // Random input traffic and 50% host stalls over a 100-sample burst.
        log_w.delete();
        request(100);
        for (int n = 0; n < 3000 && busy; n++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_p = $urandom; in_q = $urandom; in_r = $urandom; in_s = $urandom;
            fpga_msg_ack = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid     = 1'b0;
        fpga_msg_ack = 1'b1;
        wait_idle(20, "t4_timeout");
        check("t4_count", 32'(log_w.size()), 32'd101);
        if (log_w.size() == 101) check("t4_tag", 32'(log_w[100][31:16]), 32'h0000FEED);

        // Reset in the middle of a burst.
        log_w.delete();
        fpga_msg_ack = 1'b1;
        request(8);
        push_quad(32'd1, 32'd2, 32'd3, 32'd4);
        push_quad(32'd5, 32'd6, 32'd7, 32'd8);
        for (int n = 0; n < 20 && log_w.size() < 3; n++) tick();
        RESET        = 1'b1;
        fpga_msg_ack = 1'b0;
        tick();
        RESET = 1'b0;
        check("t6_words_before_reset", 32'(log_w.size()), 32'd3);
        check("t6_req_ack", 32'(req_ack), 32'd0);
        check("t6_valid", 32'(fpga_msg_valid), 32'd0);
        check("t6_msg", fpga_msg, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_drop", 32'(drop_pulse), 32'd0);
        tick();
        run_basic("t6");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
